// File: rtl/udp_tx_packet_writer_pkg.sv
// Shared definitions for the UDP TX packet writer: status word layout and writer FSM encoding.
// The UDP core unpacks status words with the same field offsets.
package udp_tx_packet_writer_pkg;

  localparam int PORT_W   = 16;
  localparam int MAC_W    = 48;
  localparam int IP_W     = 32;
  localparam int STATUS_W = PORT_W + MAC_W + IP_W;

  // Status word is {port, mac, ip} with the port in the MSBs
  localparam int IP_LSB   = 0;
  localparam int IP_MSB   = IP_W - 1;
  localparam int MAC_LSB  = IP_W;
  localparam int MAC_MSB  = IP_W + MAC_W - 1;
  localparam int PORT_LSB = IP_W + MAC_W;
  localparam int PORT_MSB = STATUS_W - 1;

  localparam int DEF_MAX_PAYLOAD = 1472;
  localparam int BYTE_CNT_W      = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    DROP   = 2'd2,
    STATUS = 2'd3
  } wr_state_e;

endpackage

// File: rtl/udp_tx_space_check.sv
// Combinational admission check: both TX FIFOs must be able to absorb one
// maximum-size payload plus its status word before a packet may start.
module udp_tx_space_check
  import udp_tx_packet_writer_pkg::*;
#(
  parameter int DATA_DEPTH   = 8192,
  parameter int STATUS_DEPTH = 256,
  parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD,
  parameter int DW           = $clog2(DATA_DEPTH),
  parameter int SW           = $clog2(STATUS_DEPTH)
) (
  input  logic          wrfull_data,
  input  logic [DW-1:0] wrusedw_data,
  input  logic          wrfull_status,
  input  logic [SW-1:0] wrusedw_status,
  output logic          space_ok
);

  // free = DEPTH-1-used >= MAX_PAYLOAD, rearranged so nothing can go negative
  localparam logic [DW-1:0] DATA_LIMIT   = DW'(DATA_DEPTH - 1 - MAX_PAYLOAD);
  localparam logic [SW-1:0] STATUS_LIMIT = SW'(STATUS_DEPTH - 2);

  assign space_ok = !wrfull_data && !wrfull_status &&
                    (wrusedw_data <= DATA_LIMIT) &&
                    (wrusedw_status < STATUS_LIMIT);

endmodule

// File: rtl/udp_tx_packet_writer.sv
// User-side producer for one UDP TX channel: writes payload bytes into the data FIFO,
// then commits exactly one {port, mac, ip} status word per packet.
module udp_tx_packet_writer
  import udp_tx_packet_writer_pkg::*;
#(
  parameter int AVL_SIZE     = 8,
  parameter int BYTE_SIZE    = 8,
  parameter int MAC_SIZE     = 48,
  parameter int IP_SIZE      = 32,
  parameter int DATA_DEPTH   = 8192,
  parameter int STATUS_DEPTH = 256,
  parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [AVL_SIZE-1:0]                   in_data,
  input  logic                                  in_valid,
  input  logic                                  in_sop,
  input  logic                                  in_eop,
  output logic                                  in_ready,
  input  logic [2*BYTE_SIZE-1:0]                dst_port,
  input  logic [MAC_SIZE-1:0]                   dst_mac,
  input  logic [IP_SIZE-1:0]                    dst_ip,
  output logic                                  wrreq_data,
  output logic [AVL_SIZE-1:0]                   data_to_fifo,
  input  logic                                  wrfull_data,
  input  logic [$clog2(DATA_DEPTH)-1:0]         wrusedw_data,
  output logic                                  wrreq_status,
  output logic [2*BYTE_SIZE+MAC_SIZE+IP_SIZE-1:0] status_to_fifo,
  input  logic                                  wrfull_status,
  input  logic [$clog2(STATUS_DEPTH)-1:0]       wrusedw_status,
  output logic                                  busy,
  output logic [31:0]                           pkt_count,
  output logic [15:0]                           trunc_count,
  output logic [15:0]                           orphan_count
);

  localparam int ST_W = 2*BYTE_SIZE + MAC_SIZE + IP_SIZE;

  wr_state_e               state, state_nxt;
  logic                    space_ok;
  logic                    accept;
  logic                    last_slot;
  logic                    sop_start;
  logic [ST_W-1:0]         dst_q;
  logic [BYTE_CNT_W-1:0]   byte_cnt;

  udp_tx_space_check #(
    .DATA_DEPTH   (DATA_DEPTH),
    .STATUS_DEPTH (STATUS_DEPTH),
    .MAX_PAYLOAD  (MAX_PAYLOAD)
  ) u_space (
    .wrfull_data    (wrfull_data),
    .wrusedw_data   (wrusedw_data),
    .wrfull_status  (wrfull_status),
    .wrusedw_status (wrusedw_status),
    .space_ok       (space_ok)
  );

  assign accept    = in_valid && in_ready;
  assign sop_start = accept && (state == IDLE) && in_sop;
  assign last_slot = (byte_cnt == BYTE_CNT_W'(MAX_PAYLOAD - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (sop_start) state_nxt = in_eop ? STATUS : DATA;
      DATA:   if (accept) begin
                if (in_eop)         state_nxt = STATUS;
                else if (last_slot) state_nxt = DROP;
              end
      DROP:   if (accept && in_eop) state_nxt = STATUS;
      STATUS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only an sop waits for space; stray bytes in IDLE are always drained
  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:        in_ready = reset_n && (!in_sop || space_ok);
      DATA, DROP:  in_ready = reset_n;
      default:     in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrreq_data     <= 1'b0;
      data_to_fifo   <= '0;
      wrreq_status   <= 1'b0;
      status_to_fifo <= '0;
      dst_q          <= '0;
      byte_cnt       <= '0;
      pkt_count      <= '0;
      trunc_count    <= '0;
      orphan_count   <= '0;
    end else begin
      wrreq_data   <= 1'b0;
      wrreq_status <= 1'b0;
      if (sop_start || (accept && state == DATA)) begin
        wrreq_data   <= 1'b1;
        data_to_fifo <= in_data;
      end
      if (sop_start) begin
        dst_q    <= {dst_port, dst_mac, dst_ip};
        byte_cnt <= BYTE_CNT_W'(1);
      end else if (accept && state == DATA) begin
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      end
      if (accept && state == IDLE && !in_sop && orphan_count != '1)
        orphan_count <= orphan_count + 16'd1;
      if (accept && state == DATA && !in_eop && last_slot && trunc_count != '1)
        trunc_count <= trunc_count + 16'd1;
      // Commit lands one cycle after the final data write
      if (state == STATUS) begin
        wrreq_status   <= 1'b1;
        status_to_fifo <= dst_q;
        pkt_count      <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_packet_writer.sv
// Bench for udp_tx_packet_writer: directed scenarios plus random packets checked
// against a queue-based model of what each packet should leave in the two FIFOs.
module tb_udp_tx_packet_writer;
  import udp_tx_packet_writer_pkg::*;

  localparam int MAXP = 1472;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [15:0] dst_port;
  logic [47:0] dst_mac;
  logic [31:0] dst_ip;
  logic        wrreq_data, wrfull_data, wrreq_status, wrfull_status, busy;
  logic [7:0]  data_to_fifo;
  logic [12:0] wrusedw_data;
  logic [95:0] status_to_fifo;
  logic [7:0]  wrusedw_status;
  logic [31:0] pkt_count;
  logic [15:0] trunc_count, orphan_count;

  udp_tx_packet_writer dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .dst_port(dst_port), .dst_mac(dst_mac), .dst_ip(dst_ip),
    .wrreq_data(wrreq_data), .data_to_fifo(data_to_fifo),
    .wrfull_data(wrfull_data), .wrusedw_data(wrusedw_data),
    .wrreq_status(wrreq_status), .status_to_fifo(status_to_fifo),
    .wrfull_status(wrfull_status), .wrusedw_status(wrusedw_status),
    .busy(busy), .pkt_count(pkt_count), .trunc_count(trunc_count),
    .orphan_count(orphan_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: bytes that must reach the data FIFO, status words that must follow
  typedef struct { logic [95:0] st; bit trunc; } st_exp_t;
  logic [7:0] exp_d[$];
  st_exp_t    exp_s[$];
  int exp_pkt = 0, exp_trunc = 0, exp_orphan = 0;

  int cyc = 0;
  int n_dw = 0, n_sw = 0, last_dw_cyc = 0, first_dw_cyc = 0;
  bit pkt_open = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : mon
    st_exp_t e;
    if (wrreq_data) begin
      n_dw++;
      if (!pkt_open) first_dw_cyc = cyc;
      pkt_open    = 1;
      last_dw_cyc = cyc;
      if (exp_d.size() > 0) chk("data", data_to_fifo, exp_d.pop_front());
      else                  chk("data_q_nonempty", exp_d.size(), 1);
    end
    if (wrreq_status) begin
      n_sw++;
      pkt_open = 0;
      if (exp_s.size() > 0) begin
        e = exp_s.pop_front();
        chk("status", status_to_fifo, e.st);
        if (!e.trunc) chk("status_gap", cyc - last_dw_cyc, 1);
        else          chk("status_after_data", cyc > last_dw_cyc, 1);
      end else begin
        chk("status_q_nonempty", exp_s.size(), 1);
      end
    end
  end

  // Present one byte and hold it until the DUT takes it
  task automatic xfer(input logic [7:0] d, input bit sop, input bit eop, output int stalls);
    in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1; stalls = 0;
    @(negedge clock);
    while (!in_ready && stalls < 20000) begin
      stalls++;
      @(negedge clock);
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [95:0] dst, input int base,
                          input int gap_pct, output int mid_stalls, output int first_stalls);
    logic [7:0] b;
    bit sop;
    int s;
    st_exp_t e;
    mid_stalls = 0; first_stalls = 0;
    dst_port = dst[PORT_MSB:PORT_LSB];
    dst_mac  = dst[MAC_MSB:MAC_LSB];
    dst_ip   = dst[IP_MSB:IP_LSB];
    e.st = dst; e.trunc = (len > MAXP);
    exp_s.push_back(e);
    exp_pkt++;
    if (len > MAXP) exp_trunc++;
    for (int i = 0; i < len; i++) begin
      b = (base >= 0) ? 8'(base + i) : 8'($urandom);
      if (i < MAXP) exp_d.push_back(b);
      if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct)
        begin repeat ($urandom_range(1, 3)) @(posedge clock); #1; end
      // A stray sop inside a packet is just payload
      sop = (i == 0) || (gap_pct > 0 && $urandom_range(99) < 3);
      xfer(b, sop, i == len - 1, s);
      if (i == 0) first_stalls = s;
      else        mid_stalls += s;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  localparam logic [95:0] DST1 = {16'h1234, 48'h02AABBCCDDEE, 32'hC0A80102};

  initial begin
    int ms, fs, s, dw0, sw0, len;
    logic [95:0] d;
    reset_n = 1'b0; in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0;
    dst_port = '0; dst_mac = '0; dst_ip = '0;
    wrfull_data = 0; wrfull_status = 0; wrusedw_data = '0; wrusedw_status = '0;
    repeat (3) @(posedge clock); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wrreq_data", wrreq_data, 0);
    chk("rst_wrreq_status", wrreq_status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_to_fifo", data_to_fifo, 0);
    chk("rst_status_to_fifo", status_to_fifo, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_trunc_count", trunc_count, 0);
    chk("rst_orphan_count", orphan_count, 0);
    reset_n = 1'b1;
    settle();

    // 4-byte packet A1..A4
    send_pkt(4, DST1, 'hA1, 0, ms, fs);
    chk("p4_busy_status", busy, 1);
    @(posedge clock); #1;
    chk("p4_status_strobe", wrreq_status, 1);
    chk("p4_status_word", status_to_fifo, DST1);
    chk("p4_pkt_count", pkt_count, 1);
    chk("p4_back_to_idle", busy, 0);
    chk("p4_consecutive", last_dw_cyc - first_dw_cyc, 3);
    settle();

    // single-byte packet
    dw0 = n_dw; sw0 = n_sw;
    send_pkt(1, {$urandom, $urandom, $urandom}, -1, 0, ms, fs);
    chk("p1_busy", busy, 1);
    @(posedge clock); #1;
    chk("p1_idle_after_2", busy, 0);
    chk("p1_status_strobe", wrreq_status, 1);
    settle();
    chk("p1_data_writes", n_dw - dw0, 1);
    chk("p1_status_writes", n_sw - sw0, 1);

    // data FIFO too full for a max payload
    dw0 = n_dw;
    wrusedw_data = 13'd6720;
    fork
      send_pkt(3, {$urandom, $urandom, $urandom}, -1, 0, ms, fs);
      begin
        repeat (5) @(negedge clock);
        chk("stall_d_ready", in_ready, 0);
        chk("stall_d_nowrite", n_dw - dw0, 0);
        @(posedge clock); #1;
        wrusedw_data = 13'd6719;
      end
    join
    chk("stall_d_cycles", fs, 5);
    settle();
    chk("stall_d_writes", n_dw - dw0, 3);
    wrusedw_data = '0;

    // status FIFO too full
    dw0 = n_dw;
    wrusedw_status = 8'd254;
    fork
      send_pkt(2, {$urandom, $urandom, $urandom}, -1, 0, ms, fs);
      begin
        repeat (5) @(negedge clock);
        chk("stall_s_ready", in_ready, 0);
        chk("stall_s_nowrite", n_dw - dw0, 0);
        @(posedge clock); #1;
        wrusedw_status = 8'd253;
      end
    join
    chk("stall_s_cycles", fs, 5);
    settle();
    wrusedw_status = '0;

    // oversize packet is truncated
    dw0 = n_dw; sw0 = n_sw;
    send_pkt(1500, {$urandom, $urandom, $urandom}, -1, 0, ms, fs);
    chk("trunc_no_stall", ms, 0);
    settle();
    chk("trunc_data_writes", n_dw - dw0, MAXP);
    chk("trunc_status_writes", n_sw - sw0, 1);
    chk("trunc_count", trunc_count, 1);

    // orphan bytes while IDLE
    dw0 = n_dw;
    for (int i = 0; i < 3; i++) begin
      xfer(8'($urandom), 1'b0, 1'($urandom), s);
      chk("orphan_ready", s, 0);
    end
    exp_orphan += 3;
    settle();
    chk("orphan_nowrite", n_dw - dw0, 0);
    chk("orphan_count", orphan_count, 3);

    // reset mid-packet: 10 bytes stay written, no status
    sw0 = n_sw;
    d = {$urandom, $urandom, $urandom};
    dst_port = d[PORT_MSB:PORT_LSB]; dst_mac = d[MAC_MSB:MAC_LSB]; dst_ip = d[IP_MSB:IP_LSB];
    for (int i = 0; i < 10; i++) begin
      exp_d.push_back(8'(i + 'h30));
      xfer(8'(i + 'h30), i == 0, 1'b0, s);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_wrreq_data", wrreq_data, 0);
    chk("mrst_data_to_fifo", data_to_fifo, 0);
    chk("mrst_status_to_fifo", status_to_fifo, 0);
    chk("mrst_pkt_count", pkt_count, 0);
    chk("mrst_trunc_count", trunc_count, 0);
    chk("mrst_orphan_count", orphan_count, 0);
    reset_n = 1'b1;
    pkt_open = 0;
    exp_pkt = 0; exp_trunc = 0; exp_orphan = 0;
    settle();
    chk("mrst_no_status", n_sw - sw0, 0);
    send_pkt(7, {$urandom, $urandom, $urandom}, -1, 0, ms, fs);
    settle();
    chk("mrst_next_pkt", pkt_count, 1);

    // random packets, gaps, orphans and FIFO levels
    for (int k = 0; k < 30; k++) begin
      wrusedw_data   = 13'($urandom_range(0, 6719));
      wrusedw_status = 8'($urandom_range(0, 253));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        xfer(8'($urandom), 1'b0, 1'($urandom), s);
        exp_orphan++;
      end
      len = ($urandom_range(99) < 85) ? int'($urandom_range(1, 40))
                                      : int'($urandom_range(1460, 1500));
      send_pkt(len, {$urandom, $urandom, $urandom}, -1, 20, ms, fs);
      chk("rnd_no_mid_stall", ms, 0);
    end
    settle();
    chk("end_data_q_empty", exp_d.size(), 0);
    chk("end_status_q_empty", exp_s.size(), 0);
    chk("end_pkt_count", pkt_count, exp_pkt);
    chk("end_trunc_count", trunc_count, exp_trunc);
    chk("end_orphan_count", orphan_count, exp_orphan);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
